// File: rtl/wave_sequencer.sv
// Waveform sequencer: selects one of four generators, ticks it from a programmable divider,
// scales its output about midscale, and only switches generators at a midscale crossing.
module wave_sequencer #(
    parameter int DATA_W         = 8,
    parameter int MID            = 127,
    parameter int SWITCH_TIMEOUT = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_op,
    input  logic [1:0]            cmd_sel,
    input  logic [7:0]            cmd_div,
    input  logic [1:0]            cmd_amp,
    input  logic [4*DATA_W-1:0]   wave_in,
    output logic [3:0]            gen_en,
    output logic [3:0]            gen_rst,
    output logic [DATA_W-1:0]     wave_out,
    output logic [1:0]            cur_sel,
    output logic                  busy,
    output logic [1:0]            dbg_state
);

    // Command handshake: a command transfers on a rising edge where cmd_valid and
    // cmd_ready are both high; the requester holds cmd_valid and its fields until then.

    localparam int TO_W = (SWITCH_TIMEOUT > 2) ? $clog2(SWITCH_TIMEOUT) : 1;
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(SWITCH_TIMEOUT - 1);
    localparam logic [DATA_W-1:0] MID_V   = DATA_W'(MID);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t              r_state;
    logic [1:0]          r_cur_sel;
    logic [7:0]          r_div;
    logic [1:0]          r_amp;
    logic                r_pend_stop;
    logic [1:0]          r_pend_sel;
    logic [7:0]          r_pend_div;
    logic [1:0]          r_pend_amp;
    logic [7:0]          r_tick_cnt;
    logic [TO_W-1:0]     r_to_cnt;
    logic [DATA_W-1:0]   r_wave_out;
    logic [3:0]          r_gen_en;
    logic [3:0]          r_gen_rst;
    logic                r_cmd_ready;
    logic                r_busy;

    logic [DATA_W-1:0]        w_sel_wave;
    logic signed [DATA_W:0]   w_diff;
    logic signed [DATA_W:0]   w_shifted;
    logic signed [DATA_W:0]   w_sum;
    logic [DATA_W-1:0]        w_scaled;
    logic                     w_tick_hit;
    logic                     w_accept;
    logic                     w_same_sel;
    logic [3:0]               w_onehot_cur;
    logic                     w_drain_exit;

    assign w_sel_wave = wave_in[32'(r_cur_sel)*DATA_W +: DATA_W];

    // Scale the signed excursion from midscale; |d| <= 128 keeps the sum inside 0..255.
    assign w_diff    = $signed({1'b0, w_sel_wave}) - $signed({1'b0, MID_V});
    assign w_shifted = w_diff >>> r_amp;
    assign w_sum     = $signed({1'b0, MID_V}) + w_shifted;
    assign w_scaled  = w_sum[DATA_W-1:0];

    assign w_tick_hit   = (r_tick_cnt == r_div);
    assign w_accept     = cmd_valid && r_cmd_ready;
    assign w_same_sel   = !cmd_op && (cmd_sel == r_cur_sel);
    assign w_onehot_cur = 4'b0001 << r_cur_sel;
    assign w_drain_exit = (w_sel_wave == MID_V) || (r_to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cur_sel   <= 2'd0;
            r_div       <= 8'd0;
            r_amp       <= 2'd0;
            r_pend_stop <= 1'b0;
            r_pend_sel  <= 2'd0;
            r_pend_div  <= 8'd0;
            r_pend_amp  <= 2'd0;
            r_tick_cnt  <= 8'd0;
            r_to_cnt    <= '0;
            r_wave_out  <= MID_V;
            r_gen_en    <= 4'b0000;
            r_gen_rst   <= 4'b1111;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_wave_out <= MID_V;
                    r_gen_en   <= 4'b0000;
                    r_gen_rst  <= 4'b1111;
                    if (w_accept && !cmd_op) begin
                        r_pend_stop <= 1'b0;
                        r_pend_sel  <= cmd_sel;
                        r_pend_div  <= cmd_div;
                        r_pend_amp  <= cmd_amp;
                        r_state     <= S_LOAD;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end

                S_LOAD: begin
                    r_cur_sel   <= r_pend_sel;
                    r_div       <= r_pend_div;
                    r_amp       <= r_pend_amp;
                    r_tick_cnt  <= 8'd0;
                    r_gen_en    <= 4'b0000;
                    r_gen_rst   <= ~(4'b0001 << r_pend_sel);
                    r_cmd_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_RUN;
                end

                S_RUN, S_DRAIN: begin
                    r_wave_out <= w_scaled;
                    r_gen_en   <= w_tick_hit ? w_onehot_cur : 4'b0000;
                    r_tick_cnt <= w_tick_hit ? 8'd0 : r_tick_cnt + 8'd1;
                    if (r_state == S_RUN) begin
                        if (w_accept) begin
                            if (w_same_sel) begin
                                r_div      <= cmd_div;
                                r_amp      <= cmd_amp;
                                r_tick_cnt <= 8'd0;
                            end else begin
                                r_pend_stop <= cmd_op;
                                r_pend_sel  <= cmd_sel;
                                r_pend_div  <= cmd_div;
                                r_pend_amp  <= cmd_amp;
                                r_to_cnt    <= '0;
                                r_state     <= S_DRAIN;
                                r_cmd_ready <= 1'b0;
                                r_busy      <= 1'b1;
                            end
                        end
                    end else if (w_drain_exit) begin
                        // Leaving the generator: suppress the tick so gen_en stays inside RUN/DRAIN.
                        r_gen_en  <= 4'b0000;
                        r_gen_rst <= 4'b1111;
                        r_to_cnt  <= '0;
                        if (r_pend_stop) begin
                            r_state     <= S_IDLE;
                            r_wave_out  <= MID_V;
                            r_cmd_ready <= 1'b1;
                            r_busy      <= 1'b0;
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign gen_en    = r_gen_en;
    assign gen_rst   = r_gen_rst;
    assign wave_out  = r_wave_out;
    assign cur_sel   = r_cur_sel;
    assign busy      = r_busy;
    assign dbg_state = r_state;

endmodule

// File: doc/wave_sequencer.md
Name: wave_sequencer

Overview:
- Controller for the function-generator waveform blocks: owns up to four 8-bit wave generators and selects one to drive the shared output.
- Generates per-generator clock-enable ticks from a programmable divider and holds unselected generators in reset.
- Applies amplitude scaling about midscale.
- Accepts commands over a valid/ready handshake; waveform switches happen only at a midscale crossing (or after a timeout), so the output never jumps.

Parameters:
- DATA_W, 8, sample width of generator inputs and output.
- MID, 127, midscale code; idle output and switch-point value.
- SWITCH_TIMEOUT, 512, max clk cycles spent in DRAIN before a forced switch.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a clk edge.
- cmd_op  input  1  0 = start/configure, 1 = stop.
- cmd_sel  input  2  generator index for start/configure.
- cmd_div  input  8  tick divider: one tick every cmd_div+1 clk cycles.
- cmd_amp  input  2  amplitude attenuation shift, 0..3.
- wave_in  input  4*DATA_W  packed generator outputs; generator i occupies bits [8i+7:8i].
- gen_en  output  4  one-hot, single-cycle tick to the selected generator.
- gen_rst  output  4  active-high reset to each generator.
- wave_out  output  DATA_W  scaled selected waveform.
- cur_sel  output  2  currently active generator index.
- busy  output  1  high in DRAIN and LOAD.

Behaviour:
- Reset (rst==0 at a clk edge, any state, including mid-DRAIN): state=IDLE, cur_sel=0, div=0, amp=0, pending cleared, tick/timeout counters=0, wave_out=MID, gen_en=0, gen_rst=4'b1111, cmd_ready=1, busy=0. All outputs are registered.
- States: IDLE, LOAD, RUN, DRAIN.
- IDLE:
  - wave_out=MID, gen_en=0, gen_rst=4'b1111, cmd_ready=1.
  - Accepted start command → latch sel/div/amp into pending, go to LOAD.
  - Accepted stop command → no effect; stay in IDLE.
- LOAD (exactly 1 cycle):
  - cur_sel, div and amp ← pending; tick counter ← 0; gen_rst=4'b1111 (one-cycle reset pulse to all generators).
  - wave_out holds its previous value; cmd_ready=0.
  - Next state RUN.
- RUN:
  - gen_rst = all ones except bit cur_sel = 0.
  - Tick counter counts 0..div. On the cycle it equals div: gen_en[cur_sel]=1 and counter ← 0. div=0 means a tick every cycle.
  - wave_out (1-cycle latency from wave_in): d = signed 9-bit (wave_in[cur_sel] − MID); wave_out = MID + (d >>> amp), truncated to 8 bits.
  - Range check: d spans −127..128, so the result stays within 0..255 and never wraps.
  - cmd_ready=1. On accept:
    - Start with cmd_sel==cur_sel: update div/amp in place next cycle, clear the tick counter, stay in RUN with no generator reset.
    - Any other accept (different sel, or stop): latch pending, clear timeout counter, go to DRAIN.
- DRAIN:
  - Ticks and output continue exactly as in RUN; cmd_ready=0; busy=1.
  - Timeout counter increments every cycle.
  - Exit when wave_in[cur_sel]==MID or timeout counter==SWITCH_TIMEOUT−1, whichever comes first: stop → IDLE; start → LOAD.
  - If both exit conditions hold in the same cycle, the exit is the same.
- cmd_valid while cmd_ready=0 is ignored; the requester holds it until accepted.
- gen_en is never asserted outside RUN/DRAIN and is never multi-hot.

Test Plan:
- Reset, then start sel=0, div=3, amp=0 → LOAD one cycle with gen_rst=1111; in RUN gen_rst=1110, gen_en=0001 every 4th cycle; wave_out equals wave_in[7:0] delayed 1 cycle.
- Amplitude: amp=2 with wave_in sweeps 255, 0, 127 → wave_out = 159, 95, 127 respectively.
- Switch sel 0→2 with wave_in[7:0] reaching 127 after 20 cycles → DRAIN for 20 cycles, then LOAD, then RUN with cur_sel=2 and gen_rst=1011; no wave_out discontinuity before the switch.
- Switch with wave_in[7:0] stuck at 200 → forced exit after exactly 512 DRAIN cycles.
- Configure same sel=0 with div=0 during RUN → stays in RUN, no gen_rst pulse, gen_en=0001 every cycle from the next cycle.
- Stop, then rst low mid-DRAIN → IDLE, wave_out=127, gen_rst=1111, cmd_ready=1 on the next edge.
